// File: rtl/camera_sensor_emulator.sv
// camera_sensor_emulator
// Transmit side of a parallel camera pixel interface (MT9V034 style). Generates
// FRAME_VALID / LINE_VALID / DATA_OUT with programmable geometry and blanking,
// and one of four test patterns chosen per frame.
//
// Optional build macro: CAMERA_EMU_FRAME_TAG_EN
//   When defined, pixel (row 0, col 0) of every frame carries FRAME_COUNT[9:0]
//   (the value after the frame increment) instead of the selected pattern.
//
// Every output is a register. The output process works from the *next* state
// and counters, so the outputs line up cycle-for-cycle with the state the FSM
// enters on that edge.
module camera_sensor_emulator #(
  parameter int WIDTH       = 752,
  parameter int HEIGHT      = 480,
  parameter int FRONT_PORCH = 1,
  parameter int LINE_BLANK  = 94,
  parameter int BACK_PORCH  = 1,
  parameter int FRAME_BLANK = 2
) (
  input  logic        PIXCLK,
  input  logic        RESET_N,
  input  logic        ENABLE,
  input  logic [1:0]  PATTERN_SEL,
  output logic        FRAME_VALID,
  output logic        LINE_VALID,
  output logic [9:0]  DATA_OUT,
  output logic        FRAME_START,
  output logic [15:0] FRAME_COUNT
);

  // Counter sizing: every counter needs at least one bit.
  localparam int COL_W = $clog2((WIDTH  < 2) ? 2 : WIDTH);
  localparam int ROW_W = $clog2((HEIGHT < 2) ? 2 : HEIGHT);

  // One shared blanking counter covers all porch/blank intervals.
  localparam int BLK_M1  = (FRONT_PORCH > LINE_BLANK) ? FRONT_PORCH : LINE_BLANK;
  localparam int BLK_M2  = (BACK_PORCH  > FRAME_BLANK) ? BACK_PORCH : FRAME_BLANK;
  localparam int BLK_MAX = (BLK_M1 > BLK_M2) ? BLK_M1 : BLK_M2;
  localparam int BLK_W   = $clog2((BLK_MAX < 2) ? 2 : BLK_MAX);

  // Terminal values: counters stop at these and return to zero.
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [BLK_W-1:0] FP_LAST  = BLK_W'(FRONT_PORCH - 1);
  localparam logic [BLK_W-1:0] LB_LAST  = BLK_W'(LINE_BLANK - 1);
  localparam logic [BLK_W-1:0] BP_LAST  = BLK_W'(BACK_PORCH - 1);
  localparam logic [BLK_W-1:0] FB_LAST  = BLK_W'(FRAME_BLANK - 1);

  localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};
  localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};
  localparam logic [BLK_W-1:0] BLK_ZERO = {BLK_W{1'b0}};
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FRONT  = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_LBLANK = 3'd3,
    ST_BACK   = 3'd4,
    ST_FBLANK = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic [1:0]        sel_q, sel_d;
  logic [15:0]       count_q, count_d;
  logic              start_d;

  logic              fv_q, fv_d;
  logic              lv_q, lv_d;
  logic [9:0]        data_q, data_d;
  logic              start_q;

  // Test-pattern value for one pixel; row/col arrive already truncated to 10 bits.
  function automatic logic [9:0] pattern_pixel(input logic [1:0] sel,
                                               input logic [9:0] row,
                                               input logic [9:0] col);
    logic [9:0] pix;
    case (sel)
      2'd0:    pix = {row[4:0], col[4:0]};
      2'd1:    pix = col;
      2'd2:    pix = row;
      2'd3:    pix = (row[3] ^ col[3]) ? 10'h3FF : 10'h000;
      default: pix = 10'h000;
    endcase
    return pix;
  endfunction

  // State register: the FSM position, restarted to IDLE by reset.
  always_ff @(posedge PIXCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: state transitions plus the row/column/blanking counters,
  // the per-frame pattern latch and the frame counter.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    blk_d   = blk_q;
    sel_d   = sel_q;
    count_d = count_q;
    start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ENABLE) begin
          state_d = ST_FRONT;
          blk_d   = BLK_ZERO;
          sel_d   = PATTERN_SEL;
          count_d = count_q + 16'd1;
          start_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FRONT: begin
        if (blk_q == FP_LAST) begin
          state_d = ST_ACTIVE;
          blk_d   = BLK_ZERO;
          row_d   = ROW_ZERO;
          col_d   = COL_ZERO;
        end else begin
          blk_d = blk_q + BLK_ONE;
        end
      end
      ST_ACTIVE: begin
        if (col_q == COL_LAST) begin
          col_d = COL_ZERO;
          blk_d = BLK_ZERO;
          if (row_q == ROW_LAST) begin
            state_d = ST_BACK;
          end else begin
            state_d = ST_LBLANK;
          end
        end else begin
          col_d = col_q + COL_ONE;
        end
      end
      ST_LBLANK: begin
        if (blk_q == LB_LAST) begin
          state_d = ST_ACTIVE;
          blk_d   = BLK_ZERO;
          row_d   = row_q + ROW_ONE;
          col_d   = COL_ZERO;
        end else begin
          blk_d = blk_q + BLK_ONE;
        end
      end
      ST_BACK: begin
        if (blk_q == BP_LAST) begin
          state_d = ST_FBLANK;
          blk_d   = BLK_ZERO;
        end else begin
          blk_d = blk_q + BLK_ONE;
        end
      end
      ST_FBLANK: begin
        if (blk_q == FB_LAST) begin
          state_d = ST_IDLE;
          blk_d   = BLK_ZERO;
          row_d   = ROW_ZERO;
          col_d   = COL_ZERO;
        end else begin
          blk_d = blk_q + BLK_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        blk_d   = BLK_ZERO;
        row_d   = ROW_ZERO;
        col_d   = COL_ZERO;
      end
    endcase
  end

  // Output decode: what the interface pins must show once the FSM enters state_d.
  always_comb begin
    fv_d   = 1'b0;
    lv_d   = 1'b0;
    data_d = 10'h000;
    case (state_d)
      ST_FRONT, ST_LBLANK, ST_BACK: begin
        fv_d = 1'b1;
      end
      ST_ACTIVE: begin
        fv_d = 1'b1;
        lv_d = 1'b1;
`ifdef CAMERA_EMU_FRAME_TAG_EN
        if ((row_d == ROW_ZERO) && (col_d == COL_ZERO)) begin
          data_d = count_d[9:0];
        end else begin
          data_d = pattern_pixel(sel_d, 10'(row_d), 10'(col_d));
        end
`else
        data_d = pattern_pixel(sel_d, 10'(row_d), 10'(col_d));
`endif
      end
      default: begin
        fv_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers: counters, pattern latch and the interface pins.
  always_ff @(posedge PIXCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      col_q   <= COL_ZERO;
      row_q   <= ROW_ZERO;
      blk_q   <= BLK_ZERO;
      sel_q   <= 2'd0;
      count_q <= 16'd0;
      fv_q    <= 1'b0;
      lv_q    <= 1'b0;
      data_q  <= 10'h000;
      start_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      blk_q   <= blk_d;
      sel_q   <= sel_d;
      count_q <= count_d;
      fv_q    <= fv_d;
      lv_q    <= lv_d;
      data_q  <= data_d;
      start_q <= start_d;
    end
  end

  assign FRAME_VALID = fv_q;
  assign LINE_VALID  = lv_q;
  assign DATA_OUT    = data_q;
  assign FRAME_START = start_q;
  assign FRAME_COUNT = count_q;

endmodule

// File: tb/tb_camera_sensor_emulator.sv
// Testbench for camera_sensor_emulator. A reference model expands each frame
// into its full per-cycle output sequence when the frame starts; a monitor
// compares the DUT pins against that sequence every cycle.
module tb_camera_sensor_emulator;

  localparam int W   = 20;
  localparam int H   = 10;
  localparam int FP  = 2;
  localparam int LB  = 3;
  localparam int BP  = 1;
  localparam int FB  = 2;
  localparam int FRAME_CYC = FP + H * W + (H - 1) * LB + BP + FB + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic        fv, lv, fs;
  logic [9:0]  data;
  logic [15:0] cnt;

  camera_sensor_emulator #(
    .WIDTH(W), .HEIGHT(H), .FRONT_PORCH(FP), .LINE_BLANK(LB),
    .BACK_PORCH(BP), .FRAME_BLANK(FB)
  ) dut (
    .PIXCLK(clk), .RESET_N(rst_n), .ENABLE(en), .PATTERN_SEL(sel),
    .FRAME_VALID(fv), .LINE_VALID(lv), .DATA_OUT(data),
    .FRAME_START(fs), .FRAME_COUNT(cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        fv;
    logic        lv;
    logic        fs;
    logic [9:0]  data;
    logic [15:0] cnt;
  } rec_t;

  rec_t        plan[$];
  rec_t        exp_q[$];
  logic [15:0] m_count = 16'd0;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic rec_t mk(input logic f, input logic l, input logic s,
                              input logic [9:0] d, input logic [15:0] c);
    rec_t r;
    r.fv = f; r.lv = l; r.fs = s; r.data = d; r.cnt = c;
    return r;
  endfunction

  // Pixel value straight from the pattern definitions, using integer arithmetic.
  function automatic logic [9:0] ref_pix(input int s, input int r, input int c,
                                         input logic [15:0] fc);
    int v;
    case (s)
      0:       v = (r % 32) * 32 + (c % 32);
      1:       v = c % 1024;
      2:       v = r % 1024;
      default: v = (((r / 8) % 2) != ((c / 8) % 2)) ? 1023 : 0;
    endcase
`ifdef CAMERA_EMU_FRAME_TAG_EN
    if (r == 0 && c == 0) v = int'(fc) % 1024;
`endif
    return v[9:0];
  endfunction

  // Lay out a whole frame, one record per output cycle, ending with the idle cycle.
  task automatic build_frame(input logic [1:0] s);
    m_count = m_count + 16'd1;
    for (int i = 0; i < FP; i++) plan.push_back(mk(1'b1, 1'b0, (i == 0), 10'h000, m_count));
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++)
        plan.push_back(mk(1'b1, 1'b1, 1'b0, ref_pix(int'(s), r, c, m_count), m_count));
      if (r < H - 1)
        for (int i = 0; i < LB; i++) plan.push_back(mk(1'b1, 1'b0, 1'b0, 10'h000, m_count));
    end
    for (int i = 0; i < BP; i++) plan.push_back(mk(1'b1, 1'b0, 1'b0, 10'h000, m_count));
    for (int i = 0; i < FB + 1; i++) plan.push_back(mk(1'b0, 1'b0, 1'b0, 10'h000, m_count));
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: each rising edge yields the expected post-edge output.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      plan.delete();
      exp_q.delete();
      m_count = 16'd0;
    end else begin
      if (plan.size() == 0) begin
        if (en) build_frame(sel);
        else plan.push_back(mk(1'b0, 1'b0, 1'b0, 10'h000, m_count));
      end
      exp_q.push_back(plan.pop_front());
    end
  end

  // Monitor: compare pins against the scoreboard half a cycle after each edge.
  initial forever begin
    rec_t e;
    @(negedge clk);
    if (!rst_n) begin
      check("reset_fv", {15'd0, fv}, 16'd0);
      check("reset_lv", {15'd0, lv}, 16'd0);
      check("reset_fs", {15'd0, fs}, 16'd0);
      check("reset_data", {6'd0, data}, 16'd0);
      check("reset_count", cnt, 16'd0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("frame_valid", {15'd0, fv}, {15'd0, e.fv});
      check("line_valid", {15'd0, lv}, {15'd0, e.lv});
      check("frame_start", {15'd0, fs}, {15'd0, e.fs});
      check("data_out", {6'd0, data}, {6'd0, e.data});
      check("frame_count", cnt, e.cnt);
    end
  end

  // Stimulus: directed phases followed by randomized ENABLE/PATTERN_SEL activity.
  initial begin
    logic found;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Continuous frames, tag pattern.
    @(negedge clk);
    en = 1'b1; sel = 2'd0;
    repeat (3 * FRAME_CYC) @(negedge clk);

    // Drop ENABLE in the second line; the frame must still complete.
    en = 1'b0;
    repeat (FRAME_CYC + 5) @(negedge clk);
    en = 1'b1;
    repeat (FP + W + LB + 5) @(negedge clk);
    en = 1'b0;
    repeat (2 * FRAME_CYC) @(negedge clk);

    // Change the pattern select mid-frame: applies only from the next frame.
    en = 1'b1; sel = 2'd0;
    repeat (FP + 5) @(negedge clk);
    sel = 2'd3;
    repeat (2 * FRAME_CYC) @(negedge clk);

    // Randomized activity.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 2) en = ~en;
      if ($urandom_range(0, 99) < 5) sel = 2'($urandom_range(0, 3));
    end

    // Reset during an active line: outputs must clear without waiting for a clock.
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME_CYC && !found; i++) begin
      @(negedge clk);
      if (lv) found = 1'b1;
    end
    check("wait_active_timeout", {15'd0, found}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_fv", {15'd0, fv}, 16'd0);
    check("async_reset_lv", {15'd0, lv}, 16'd0);
    check("async_reset_data", {6'd0, data}, 16'd0);
    check("async_reset_count", cnt, 16'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2 * FRAME_CYC) @(negedge clk);

    en = 1'b0;
    repeat (FRAME_CYC + 5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
